// File: rtl/memory_access_stage.sv
// RV64 memory-access stage: loads/stores over a req/ack data-memory port, ALU results passed through to writeback.
// Optional build macro MEM_TIMEOUT_EN adds a watchdog that faults an access whose ack never arrives.
module memory_access_stage #(
   parameter int XLEN = 64
`ifdef MEM_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [XLEN-1:0] ALUResult,
   input  logic [XLEN-1:0] storeData,
   input  logic [2:0]      funct3,
   input  logic            MemRead,
   input  logic            MemWrite,
   input  logic            RegWrite,
   input  logic [4:0]      rd,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [7:0]      mem_wstrb,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            wb_valid,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wb_rd,
   output logic            wb_RegWrite,
   output logic            fault
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [2:0]      r_lsb;
   logic [2:0]      r_funct3;
   logic            r_is_load;
   logic            r_regwrite;
   logic            r_mem_req;
   logic            r_mem_we;
   logic [XLEN-1:0] r_mem_addr;
   logic [XLEN-1:0] r_mem_wdata;
   logic [7:0]      r_mem_wstrb;
   logic            r_wb_valid;
   logic [XLEN-1:0] r_wb_data;
   logic [4:0]      r_wb_rd;
   logic            r_wb_regwrite;
   logic            r_fault;
`ifdef MEM_TIMEOUT_EN
   logic [7:0]      r_timer;
`endif

   logic            w_accept;
   logic            w_is_mem;
   logic            w_misaligned;
   logic            w_illegal;
   logic            w_fault;
   logic [7:0]      w_size_mask;
   logic [XLEN-1:0] w_lane;
   logic [XLEN-1:0] w_load_value;

   assign ex_ready = (r_state == S_IDLE);
   assign w_accept = ex_valid && ex_ready;
   assign w_is_mem = MemRead || MemWrite;

   // NOTE: every variable written in an always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_misaligned = 1'b0;
      w_size_mask  = 8'h01;
      unique case (funct3[1:0])
         2'b00: w_size_mask = 8'h01;
         2'b01: begin
            w_size_mask  = 8'h03;
            w_misaligned = ALUResult[0];
         end
         2'b10: begin
            w_size_mask  = 8'h0F;
            w_misaligned = (ALUResult[1:0] != 2'b00);
         end
         default: begin
            w_size_mask  = 8'hFF;
            w_misaligned = (ALUResult[2:0] != 3'b000);
         end
      endcase
   end

   // Unsigned stores and funct3=111 have no encoding in RV64.
   assign w_illegal = (MemRead && MemWrite) || (funct3 == 3'b111) || (MemWrite && funct3[2]);
   assign w_fault   = w_misaligned || w_illegal;

   always_comb begin
      w_lane       = mem_rdata >> {r_lsb, 3'b000};
      w_load_value = w_lane;
      unique case (r_funct3)
         3'b000:  w_load_value = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
         3'b001:  w_load_value = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
         3'b010:  w_load_value = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
         3'b100:  w_load_value = {{(XLEN-8){1'b0}}, w_lane[7:0]};
         3'b101:  w_load_value = {{(XLEN-16){1'b0}}, w_lane[15:0]};
         3'b110:  w_load_value = {{(XLEN-32){1'b0}}, w_lane[31:0]};
         default: w_load_value = w_lane;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_lsb         <= '0;
         r_funct3      <= '0;
         r_is_load     <= 1'b0;
         r_regwrite    <= 1'b0;
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_mem_wstrb   <= '0;
         r_wb_valid    <= 1'b0;
         r_wb_data     <= '0;
         r_wb_rd       <= '0;
         r_wb_regwrite <= 1'b0;
         r_fault       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         r_timer       <= '0;
`endif
      end else begin
         r_wb_valid <= 1'b0;
         r_fault    <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_wb_rd <= rd;
                  if (!w_is_mem) begin
                     r_wb_valid    <= 1'b1;
                     r_wb_data     <= ALUResult;
                     r_wb_regwrite <= RegWrite;
                  end else if (w_fault) begin
                     r_wb_valid    <= 1'b1;
                     r_fault       <= 1'b1;
                     r_wb_data     <= '0;
                     r_wb_regwrite <= 1'b0;
                  end else begin
                     r_state     <= S_ACCESS;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= MemWrite;
                     r_mem_addr  <= {ALUResult[XLEN-1:3], 3'b000};
                     r_mem_wdata <= MemWrite ? (storeData << {ALUResult[2:0], 3'b000}) : '0;
                     r_mem_wstrb <= MemWrite ? (w_size_mask << ALUResult[2:0]) : 8'h00;
                     r_lsb       <= ALUResult[2:0];
                     r_funct3    <= funct3;
                     r_is_load   <= MemRead;
                     r_regwrite  <= RegWrite;
`ifdef MEM_TIMEOUT_EN
                     r_timer     <= '0;
`endif
                  end
               end
            end
            S_ACCESS: begin
               if (mem_ack) begin
                  r_state       <= S_DONE;
                  r_mem_req     <= 1'b0;
                  r_wb_valid    <= 1'b1;
                  r_wb_data     <= r_is_load ? w_load_value : '0;
                  r_wb_regwrite <= r_is_load && r_regwrite;
`ifdef MEM_TIMEOUT_EN
               end else if (r_timer == 8'(TIMEOUT_CYCLES - 1)) begin
                  // This is the TIMEOUT_CYCLES-th cycle without an ack.
                  r_state       <= S_DONE;
                  r_mem_req     <= 1'b0;
                  r_wb_valid    <= 1'b1;
                  r_fault       <= 1'b1;
                  r_wb_data     <= '0;
                  r_wb_regwrite <= 1'b0;
               end else begin
                  r_timer <= r_timer + 8'd1;
`endif
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign mem_wstrb   = r_mem_wstrb;
   assign wb_valid    = r_wb_valid;
   assign wb_data     = r_wb_data;
   assign wb_rd       = r_wb_rd;
   assign wb_RegWrite = r_wb_regwrite;
   assign fault       = r_fault;

endmodule
